bcd_display_ctrl: RTL and testbench

Parametrised multi-digit BCD counter/display controller driving the seven-segment PIO outputs and LED pattern bank of the board-level system. Generalises the fixed five-digit, 18-LED, two-bit-mode arrangement to N digits with a selectable tick rate, up/down/hold/shift-load modes and a wrap counter. Sits between the switch/button PIO inputs and the segment and LED PIO outputs in the top level.

---
 rtl/bcd_display_ctrl_if.sv | 24 ++
 rtl/bcd_display_ctrl.sv | 177 +++++++++++++++++
 tb/tb_bcd_display_ctrl.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_ctrl_if.sv
// Bundle of the mode/data inputs and display outputs of bcd_display_ctrl.
// The master drives the mode/data inputs; the slave drives the display outputs.
interface bcd_display_ctrl_if #(
  parameter int unsigned NUM_DIGITS = 5,
  parameter int unsigned LED_WIDTH  = 18
);
  logic [1:0]              modes_in;
  logic [3:0]              bcd_in;
  logic                    spcont_in;
  logic [8*NUM_DIGITS-1:0] seg_out;
  logic [LED_WIDTH-1:0]    pattern_out;
  logic [7:0]              cout_out;
  logic                    tick_out;

  modport master (
    output modes_in, bcd_in, spcont_in,
    input  seg_out, pattern_out, cout_out, tick_out
  );

  modport slave (
    input  modes_in, bcd_in, spcont_in,
    output seg_out, pattern_out, cout_out, tick_out
  );
endinterface

// File: rtl/bcd_display_ctrl.sv
// N-digit BCD up/down/shift-load counter with seven-segment, walking-LED and wrap outputs.
// Optional LEADING_ZERO_BLANK_EN blanks digits above the most significant non-zero digit.
module bcd_display_ctrl #(
  parameter int unsigned NUM_DIGITS     = 5,
  parameter int unsigned LED_WIDTH      = 18,
  parameter int unsigned SLOW_DIV       = 50000000,
  parameter int unsigned FAST_DIV       = 12500000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input logic              clk_clk,
  input logic              reset_reset_n,
  bcd_display_ctrl_if.slave bus
);

  localparam int unsigned MaxDiv = (SLOW_DIV > FAST_DIV) ? SLOW_DIV : FAST_DIV;
  localparam int unsigned PW     = $clog2(MaxDiv);

  function automatic logic [6:0] enc7(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'h3F;
      4'd1:    s = 7'h06;
      4'd2:    s = 7'h5B;
      4'd3:    s = 7'h4F;
      4'd4:    s = 7'h66;
      4'd5:    s = 7'h6D;
      4'd6:    s = 7'h7D;
      4'd7:    s = 7'h07;
      4'd8:    s = 7'h7F;
      default: s = 7'h6F;
    endcase
    return s;
  endfunction

  function automatic logic [8*NUM_DIGITS-1:0] seg_image(input logic [NUM_DIGITS-1:0][3:0] dig);
    logic [8*NUM_DIGITS-1:0] img;
    logic [7:0]              b;
`ifdef LEADING_ZERO_BLANK_EN
    logic                    lead;
    lead = 1'b1;
`endif
    img = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      b = {1'b0, enc7(dig[i])};
`ifdef LEADING_ZERO_BLANK_EN
      if (dig[i] != 4'd0) lead = 1'b0;
      if (lead && (i != 0)) b = 8'h00;
`endif
      img[8*i +: 8] = SEG_ACTIVE_LOW ? ~b : b;
    end
    return img;
  endfunction

  logic [1:0]                 r_mode_s1, r_mode_s2;
  logic [3:0]                 r_bcd_s1, r_bcd_s2;
  logic                       r_sp_s1, r_sp_s2, r_sp_prev;
  logic [PW-1:0]              r_presc;
  logic                       r_tick;
  logic [NUM_DIGITS-1:0][3:0] r_digit;
  logic [8*NUM_DIGITS-1:0]    r_seg;
  logic [LED_WIDTH-1:0]       r_pat;
  logic [7:0]                 r_cout;

  logic [PW-1:0]              w_div_m1;
  logic                       w_sp_chg;
  logic [NUM_DIGITS-1:0][3:0] w_digit_nxt;
  logic [LED_WIDTH-1:0]       w_pat_nxt;
  logic [7:0]                 w_cout_nxt;
  logic                       w_carry;

  assign w_div_m1 = r_sp_s2 ? PW'(FAST_DIV - 1) : PW'(SLOW_DIV - 1);
  assign w_sp_chg = r_sp_s2 ^ r_sp_prev;

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_mode_s1 <= '0;
      r_mode_s2 <= '0;
      r_bcd_s1  <= '0;
      r_bcd_s2  <= '0;
      r_sp_s1   <= 1'b0;
      r_sp_s2   <= 1'b0;
      r_sp_prev <= 1'b0;
    end else begin
      r_mode_s1 <= bus.modes_in;
      r_mode_s2 <= r_mode_s1;
      r_bcd_s1  <= bus.bcd_in;
      r_bcd_s2  <= r_bcd_s1;
      r_sp_s1   <= bus.spcont_in;
      r_sp_s2   <= r_sp_s1;
      r_sp_prev <= r_sp_s2;
    end
  end

  // A speed change restarts the prescaler so the new period starts cleanly.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (w_sp_chg) begin
      r_presc <= '0;
      r_tick  <= 1'b0;
    end else if (r_presc == w_div_m1) begin
      r_presc <= '0;
      r_tick  <= 1'b1;
    end else begin
      r_presc <= r_presc + PW'(1);
      r_tick  <= 1'b0;
    end
  end

  always_comb begin
    w_digit_nxt = r_digit;
    w_pat_nxt   = r_pat;
    w_cout_nxt  = r_cout;
    w_carry     = 1'b1;
    if (r_tick) begin
      unique case (r_mode_s2)
        2'b00: ;
        2'b01: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
              if (r_digit[i] == 4'd9) begin
                w_digit_nxt[i] = 4'd0;
              end else begin
                w_digit_nxt[i] = r_digit[i] + 4'd1;
                w_carry        = 1'b0;
              end
            end
          end
          if (w_carry) w_cout_nxt = r_cout + 8'd1;
          w_pat_nxt = {r_pat[LED_WIDTH-2:0], r_pat[LED_WIDTH-1]};
        end
        2'b10: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w_carry) begin
              if (r_digit[i] == 4'd0) begin
                w_digit_nxt[i] = 4'd9;
              end else begin
                w_digit_nxt[i] = r_digit[i] - 4'd1;
                w_carry        = 1'b0;
              end
            end
          end
          if (w_carry) w_cout_nxt = r_cout + 8'd1;
          w_pat_nxt = {r_pat[0], r_pat[LED_WIDTH-1:1]};
        end
        2'b11: begin
          for (int i = 1; i < NUM_DIGITS; i++) begin
            w_digit_nxt[i] = r_digit[i-1];
          end
          w_digit_nxt[0] = (r_bcd_s2 > 4'd9) ? 4'd9 : r_bcd_s2;
          w_pat_nxt      = ~r_pat;
        end
      endcase
    end
  end

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      r_digit <= '0;
      r_seg   <= seg_image('0);
      r_pat   <= LED_WIDTH'(1);
      r_cout  <= '0;
    end else begin
      r_digit <= w_digit_nxt;
      r_seg   <= seg_image(r_digit);
      r_pat   <= w_pat_nxt;
      r_cout  <= w_cout_nxt;
    end
  end

  assign bus.seg_out     = r_seg;
  assign bus.pattern_out = r_pat;
  assign bus.cout_out    = r_cout;
  assign bus.tick_out    = r_tick;

endmodule

// File: tb/tb_bcd_display_ctrl.sv
// Scoreboard bench for bcd_display_ctrl: a decimal-value model predicts each tick's display.
module tb_bcd_display_ctrl;
  localparam int unsigned ND = 2;
  localparam int unsigned LW = 4;
  localparam int unsigned SD = 4;
  localparam int unsigned FD = 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  bcd_display_ctrl_if #(.NUM_DIGITS(ND), .LED_WIDTH(LW)) bus ();

  bcd_display_ctrl #(
    .NUM_DIGITS    (ND),
    .LED_WIDTH     (LW),
    .SLOW_DIV      (SD),
    .FAST_DIV      (FD),
    .SEG_ACTIVE_LOW(1'b1)
  ) dut (
    .clk_clk      (clk),
    .reset_reset_n(rst_n),
    .bus          (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0]   seg;
    logic [LW-1:0] pat;
    logic [7:0]    cout;
    int            due;
  } exp_t;

  exp_t          sb_q[$];
  int            n_vec = 0;
  int            n_bad = 0;
  int            cyc   = 0;
  int            m_v;
  logic [LW-1:0] m_pat;
  logic [7:0]    m_cout;
  logic [6:0]    seg_hi [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F};

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] exp_byte(input int d, input bit blank);
    logic [7:0] b;
    b = blank ? 8'h00 : {1'b0, seg_hi[d]};
    return ~b;
  endfunction

  function automatic logic [15:0] exp_seg(input int v);
    bit bl;
    bl = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    bl = (v < 10);
`endif
    return {exp_byte(v / 10, bl), exp_byte(v % 10, 1'b0)};
  endfunction

  // Model and scoreboard; inputs only change just after a tick, so the live
  // input values equal what the DUT's synchronisers present at the update edge.
  always @(negedge clk) begin
    exp_t e;
    int   ld;
    cyc++;
    if (!rst_n) begin
      sb_q.delete();
      m_v    = 0;
      m_pat  = LW'(1);
      m_cout = 8'd0;
    end else begin
      while (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
        e = sb_q.pop_front();
        check_val("seg_out", 32'(bus.seg_out), 32'(e.seg));
        check_val("pattern_out", 32'(bus.pattern_out), 32'(e.pat));
        check_val("cout_out", 32'(bus.cout_out), 32'(e.cout));
      end
      if (bus.tick_out) begin
        case (bus.modes_in)
          2'b01: begin
            m_v = (m_v + 1) % 100;
            if (m_v == 0) m_cout = m_cout + 8'd1;
            m_pat = {m_pat[LW-2:0], m_pat[LW-1]};
          end
          2'b10: begin
            if (m_v == 0) begin
              m_v    = 99;
              m_cout = m_cout + 8'd1;
            end else begin
              m_v = m_v - 1;
            end
            m_pat = {m_pat[0], m_pat[LW-1:1]};
          end
          2'b11: begin
            ld    = (bus.bcd_in > 4'd9) ? 9 : int'(bus.bcd_in);
            m_v   = (m_v % 10) * 10 + ld;
            m_pat = ~m_pat;
          end
          default: ;
        endcase
        e.seg  = exp_seg(m_v);
        e.pat  = m_pat;
        e.cout = m_cout;
        e.due  = cyc + 2;
        sb_q.push_back(e);
      end
    end
  end

  task automatic wait_tick(output int tcyc);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.tick_out && n < 40);
    check_val("tick_seen", 32'(bus.tick_out), 32'd1);
    #1;
    tcyc = cyc;
  endtask

  task automatic do_reset(input logic [1:0] mode, input logic [3:0] bcd, output int rel);
    rst_n         = 1'b0;
    bus.modes_in  = mode;
    bus.bcd_in    = bcd;
    bus.spcont_in = 1'b0;
    repeat (3) @(negedge clk);
    check_val("rst_seg", 32'(bus.seg_out), 32'(exp_seg(0)));
    check_val("rst_pattern", 32'(bus.pattern_out), 32'd1);
    check_val("rst_cout", 32'(bus.cout_out), 32'd0);
    check_val("rst_tick", 32'(bus.tick_out), 32'd0);
    #1;
    rst_n = 1'b1;
    rel   = cyc;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, t1, t2, t3;

    // Count up from reset, through the 99 -> 00 wrap.
    do_reset(2'b01, 4'd0, t0);
    wait_tick(t1);
    check_val("first_tick_gap", 32'(t1 - t0), 32'(SD));
    wait_tick(t2);
    check_val("slow_tick_gap", 32'(t2 - t1), 32'(SD));
    repeat (103) wait_tick(t1);
    check_val("cout_after_wrap", 32'(bus.cout_out), 32'd1);

    // Count down from reset: 99 then 98.
    do_reset(2'b10, 4'd0, t0);
    wait_tick(t1);
    wait_tick(t1);
    repeat (2) @(negedge clk);
    check_val("down_98_seg", 32'(bus.seg_out), 32'h9080);
    check_val("down_cout", 32'(bus.cout_out), 32'd1);

    // Shift-load 3 then 12 (clamped to 9), then hold.
    do_reset(2'b11, 4'd3, t0);
    wait_tick(t1);
    bus.bcd_in = 4'd12;
    wait_tick(t1);
    repeat (2) @(negedge clk);
    check_val("shift_39_seg", 32'(bus.seg_out), 32'hB090);
    check_val("shift_cout", 32'(bus.cout_out), 32'd0);
    check_val("shift_pattern", 32'(bus.pattern_out), 32'd1);
    wait_tick(t1);
    bus.modes_in = 2'b00;
    repeat (3) wait_tick(t1);

    // Speed switch just after a tick: prescaler restarts, then FAST_DIV period.
    bus.modes_in = 2'b01;
    wait_tick(t1);
    bus.spcont_in = 1'b1;
    wait_tick(t2);
    check_val("speed_switch_gap", 32'(t2 - t1), 32'd5);
    wait_tick(t3);
    check_val("fast_tick_gap0", 32'(t3 - t2), 32'(FD));
    wait_tick(t1);
    check_val("fast_tick_gap1", 32'(t1 - t3), 32'(FD));

    // Asynchronous reset mid-count.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_rst_seg", 32'(bus.seg_out), 32'(exp_seg(0)));
    check_val("async_rst_pattern", 32'(bus.pattern_out), 32'd1);
    check_val("async_rst_cout", 32'(bus.cout_out), 32'd0);
    check_val("async_rst_tick", 32'(bus.tick_out), 32'd0);
    bus.spcont_in = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    rst_n = 1'b1;
    t0    = cyc;
    wait_tick(t1);
    check_val("post_rst_tick_gap", 32'(t1 - t0), 32'(SD));
    wait_tick(t1);

    repeat (4) @(negedge clk);
    check_val("scoreboard_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
